combo_sender: RTL and testbench

- Serial keypad driver for the 6-digit combination lock. It is the transmit end of the lock's enter/in_1/in_0 symbol interface.
- On a start request it:
  - resets the lock,
  - sends a latched 6-bit combination one digit at a time with alternating enter phase,
  - watches the lock's 7-segment feedback for the unlocked pattern,
  - retries on timeout up to a limit.
- Sits between the front-panel controller and the lock; drives the lock's reset, enter, in_1 and in_0 inputs.

---
 rtl/lock_pkg.sv | 17 +
 rtl/symbol_enc.sv | 23 ++
 rtl/combo_sender.sv | 167 ++++++++++++++++
 tb/tb_combo_sender.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared constants for the combination lock and its keypad driver.
// Contents: FSM state encoding, 7-segment display patterns, default combination.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [6:0] LOCKED       = 7'b1000111;
    localparam logic [6:0] UNLOCKED     = 7'b1000001;
    localparam logic [5:0] DEFAULT_CODE = 6'b110110;

endpackage

// File: rtl/symbol_enc.sv
// symbol_enc: maps one combination digit and its position to the lock's
// enter/in_1/in_0 symbol; all-zero when inactive (the idle symbol).
// Ports:
//   digit   in  digit value to send
//   idx_lsb in  LSB of the digit index; even digits carry enter=1
//   active  in  high while a digit is being sent
//   enter   out symbol phase bit
//   in_1    out high for a 1 digit
//   in_0    out high for a 0 digit
module symbol_enc (
    input  logic digit,
    input  logic idx_lsb,
    input  logic active,
    output logic enter,
    output logic in_1,
    output logic in_0
);

    assign enter = active & ~idx_lsb;
    assign in_1  = active & digit;
    assign in_0  = active & ~digit;

endmodule

// File: rtl/combo_sender.sv
// combo_sender: serial keypad driver that resets the lock, sends a latched
// 6-bit combination MSB first, watches for the unlocked display and retries.
// Ports:
//   clock    in  system clock
//   reset    in  asynchronous active-low reset
//   start    in  operation request, sampled only in IDLE
//   code     in  6-bit combination, latched on an accepted start
//   seg_disp in  lock 7-segment feedback
//   lock_rst out active-high reset to the lock
//   enter    out symbol phase bit
//   in_1     out current digit is 1
//   in_0     out current digit is 0
//   busy     out high outside IDLE
//   done     out one-cycle end-of-operation pulse
//   success  out result of the last operation
//   attempts out attempts used by the last operation
module combo_sender
    import lock_pkg::*;
#(
    parameter int         HOLD_CYC = 2,
    parameter int         WAIT_CYC = 8,
    parameter int         MAX_TRY  = 3,
    parameter logic [6:0] UNLOCKED = lock_pkg::UNLOCKED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] code,
    input  logic [6:0] seg_disp,
    output logic       lock_rst,
    output logic       enter,
    output logic       in_1,
    output logic       in_0,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic [2:0] attempts
);

    localparam logic [3:0] H_LAST = 4'(HOLD_CYC - 1);
    localparam logic [7:0] W_LAST = 8'(WAIT_CYC - 1);
    localparam logic [2:0] T_MAX  = 3'(MAX_TRY);

    state_t     state_q, state_d;
    logic [5:0] code_q, code_d;
    logic [2:0] d_q, d_d;
    logic [3:0] h_q, h_d;
    logic [7:0] w_q, w_d;
    logic [2:0] try_q, try_d;
    logic       success_q, success_d;
    logic [2:0] attempts_q, attempts_d;
    logic       lock_rst_q, lock_rst_d;
    logic       enter_q, enter_d;
    logic       in_1_q, in_1_d;
    logic       in_0_q, in_0_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        d_d        = d_q;
        h_d        = h_q;
        w_d        = w_q;
        try_d      = try_q;
        success_d  = success_q;
        attempts_d = attempts_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = RST;
                code_d    = code;
                try_d     = 3'd1;
                success_d = 1'b0;
            end
            RST: begin
                state_d = SEND;
                d_d     = 3'd0;
                h_d     = 4'd0;
            end
            SEND: if (h_q != H_LAST) begin
                h_d = h_q + 4'd1;
            end else if (d_q != 3'd5) begin
                d_d = d_q + 3'd1;
                h_d = 4'd0;
            end else begin
                state_d = WAIT;
                w_d     = 8'd0;
            end
            // A match wins even on the final wait cycle.
            WAIT: if (seg_disp == UNLOCKED) begin
                state_d    = DONE;
                success_d  = 1'b1;
                attempts_d = try_q;
            end else if (w_q != W_LAST) begin
                w_d = w_q + 8'd1;
            end else if (try_q < T_MAX) begin
                state_d = RST;
                try_d   = try_q + 3'd1;
            end else begin
                state_d    = DONE;
                attempts_d = try_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        lock_rst_d = state_d == RST;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
    end

    symbol_enc u_enc (
        .digit  (code_d[3'd5 - d_d]),
        .idx_lsb(d_d[0]),
        .active (state_d == SEND),
        .enter  (enter_d),
        .in_1   (in_1_d),
        .in_0   (in_0_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            code_q     <= '0;
            d_q        <= '0;
            h_q        <= '0;
            w_q        <= '0;
            try_q      <= '0;
            success_q  <= 1'b0;
            attempts_q <= '0;
            lock_rst_q <= 1'b0;
            enter_q    <= 1'b0;
            in_1_q     <= 1'b0;
            in_0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            d_q        <= d_d;
            h_q        <= h_d;
            w_q        <= w_d;
            try_q      <= try_d;
            success_q  <= success_d;
            attempts_q <= attempts_d;
            lock_rst_q <= lock_rst_d;
            enter_q    <= enter_d;
            in_1_q     <= in_1_d;
            in_0_q     <= in_0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign lock_rst = lock_rst_q;
    assign enter    = enter_q;
    assign in_1     = in_1_q;
    assign in_0     = in_0_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign success  = success_q;
    assign attempts = attempts_q;

endmodule

// File: tb/tb_combo_sender.sv
// tb_combo_sender: directed self-checking bench for combo_sender (default and HOLD_CYC=1).
module tb_combo_sender;
    import lock_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;
    logic [5:0] code;
    logic [6:0] seg_disp;
    logic       lr0, en0, i10, i00, b0, dn0, s0;
    logic       lr1, en1, i11, i01, b1, dn1, s1;
    logic [2:0] a0, a1;
    logic       o_lock_rst, o_enter, o_in_1, o_in_0, o_busy, o_done, o_success;
    logic [2:0] o_attempts;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0] sym_log [0:127];
    logic       rst_log [0:127];
    int         n_rst, busy_n, done_k;
    logic       fin_s, succ0;
    logic [2:0] fin_a;

    logic [2:0] exp_a [0:5] = '{3'b110, 3'b010, 3'b101, 3'b010, 3'b110, 3'b001};
    logic [2:0] exp_b [0:5] = '{3'b110, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001};

    always #5 clock = ~clock;

    combo_sender dut0 (
        .clock(clock), .reset(reset), .start(start & ~sel), .code(code), .seg_disp(seg_disp),
        .lock_rst(lr0), .enter(en0), .in_1(i10), .in_0(i00), .busy(b0), .done(dn0),
        .success(s0), .attempts(a0)
    );

    combo_sender #(.HOLD_CYC(1)) dut1 (
        .clock(clock), .reset(reset), .start(start & sel), .code(code), .seg_disp(seg_disp),
        .lock_rst(lr1), .enter(en1), .in_1(i11), .in_0(i01), .busy(b1), .done(dn1),
        .success(s1), .attempts(a1)
    );

    assign o_lock_rst = sel ? lr1 : lr0;
    assign o_enter    = sel ? en1 : en0;
    assign o_in_1     = sel ? i11 : i10;
    assign o_in_0     = sel ? i01 : i00;
    assign o_busy     = sel ? b1 : b0;
    assign o_done     = sel ? dn1 : dn0;
    assign o_success  = sel ? s1 : s0;
    assign o_attempts = sel ? a1 : a0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One operation; k counts samples after the accepting edge (k=0 is RST).
    task automatic run(input logic [5:0] c, input int open_k, input int alt_k);
        code  = c;
        start = 1'b1;
        tick();
        start  = 1'b0;
        n_rst  = 0;
        busy_n = 0;
        done_k = -1;
        succ0  = o_success;
        for (int k = 0; k < 120 && done_k < 0; k++) begin
            sym_log[k] = {o_enter, o_in_1, o_in_0};
            rst_log[k] = o_lock_rst;
            if (o_lock_rst) n_rst++;
            if (o_busy) busy_n++;
            if (o_done) begin
                done_k = k;
                fin_s  = o_success;
                fin_a  = o_attempts;
            end
            seg_disp = (k == open_k) ? UNLOCKED : LOCKED;
            start    = (k == alt_k);
            code     = (k == alt_k) ? ~c : c;
            tick();
        end
        start    = 1'b0;
        seg_disp = LOCKED;
        check("done_seen", done_k >= 0, 1);
        check("idle_after", {o_busy, o_done}, 0);
    endtask

    task automatic check_syms(input string tag, input int hold, input logic [2:0] exp [0:5]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < hold; j++)
                check(tag, sym_log[1 + i * hold + j], exp[i]);
        check({tag, "_rst"}, {rst_log[0], sym_log[0]}, 4'b1000);
        check({tag, "_end"}, sym_log[1 + 6 * hold], 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        code     = '0;
        seg_disp = LOCKED;
        tick();
        tick();
        check("reset_outs", {o_lock_rst, o_enter, o_in_1, o_in_0, o_busy, o_done, o_success, o_attempts}, 0);
        reset = 1'b1;
        tick();

        // Correct code, immediate open
        run(6'b110110, 13, -1);
        check_syms("open_sym", 2, exp_a);
        check("open_done_k", done_k, 14);
        check("open_res", {fin_s, fin_a}, {1'b1, 3'd1});
        check("open_nrst", n_rst, 1);

        // Wrong code, all retries exhausted
        run(6'b000000, -1, -1);
        check("wrong_clr_succ", succ0, 0);
        check("wrong_nrst", n_rst, 3);
        check("wrong_res", {fin_s, fin_a}, {1'b0, 3'd3});
        check("wrong_busy", busy_n, 64);
        check("wrong_done_k", done_k, 63);

        // Late open on the last wait cycle of attempt 2
        run(6'b110110, 41, -1);
        check("late_res", {fin_s, fin_a}, {1'b1, 3'd2});
        check("late_nrst", n_rst, 2);
        check("late_done_k", done_k, 42);

        // Start with another code while sending is ignored
        run(6'b110110, 13, 5);
        check_syms("busy_sym", 2, exp_a);
        check("busy_res", {fin_s, fin_a}, {1'b1, 3'd1});

        // Reset during digit 3
        code  = 6'b110110;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre_reset_sym", {o_enter, o_in_1, o_in_0}, 3'b010);
        reset = 1'b0;
        #1;
        check("async_reset", {o_lock_rst, o_enter, o_in_1, o_in_0, o_busy, o_done, o_success, o_attempts}, 0);
        tick();
        reset = 1'b1;
        begin
            int dn = 0;
            for (int k = 0; k < 30; k++) begin
                if (o_done || o_lock_rst) dn++;
                tick();
            end
            check("no_done_after_reset", dn, 0);
        end
        run(6'b110110, 13, -1);
        check_syms("rerun_sym", 2, exp_a);
        check("rerun_res", {fin_s, fin_a}, {1'b1, 3'd1});

        // HOLD_CYC=1 instance
        sel = 1'b1;
        tick();
        run(6'b101010, 7, -1);
        check_syms("h1_sym", 1, exp_b);
        check("h1_done_k", done_k, 8);
        check("h1_res", {fin_s, fin_a}, {1'b1, 3'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
